wb_sdram_arbiter: RTL

Two-master Wishbone B4 arbiter that shares the single SDRAM controller slave port between the CPU instruction bus and data bus in the picorv32 Wishbone SoC. It sits in the wb_clk domain, between the two CPU-side masters and the SDRAM controller's Wishbone slave. It provides round-robin grant with bus locking for the full duration of CYC, so bursts (CTI/BTE) pass through intact. A watchdog terminates any transfer the slave fails to acknowledge.

---
 rtl/wb_sdram_arbiter_pkg.sv | 29 ++
 rtl/wb_watchdog.sv | 39 +++
 rtl/wb_sdram_arbiter.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/wb_sdram_arbiter_pkg.sv
// Shared Wishbone encodings and arbiter state for the SDRAM port arbiter.
package wb_sdram_arbiter_pkg;

  typedef enum logic [2:0] {
    CTI_CLASSIC = 3'b000,
    CTI_CONST   = 3'b001,
    CTI_INCR    = 3'b010,
    CTI_EOB     = 3'b111
  } wb_cti_e;

  typedef enum logic [1:0] {
    BTE_LINEAR = 2'b00,
    BTE_WRAP4  = 2'b01,
    BTE_WRAP8  = 2'b10,
    BTE_WRAP16 = 2'b11
  } wb_bte_e;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'b00,
    ARB_OWN0 = 2'b01,
    ARB_OWN1 = 2'b10
  } arb_state_e;

  // Counter width able to hold 0..limit; a disabled watchdog still gets one bit.
  function automatic int unsigned cnt_width(input int unsigned limit);
    return (limit > 0) ? $clog2(limit + 1) : 1;
  endfunction

endpackage

// File: rtl/wb_watchdog.sv
// Stall watchdog: counts cycles of an enabled request without termination and
// pulses expire_o for one cycle when the limit is reached.
module wb_watchdog
  import wb_sdram_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic clr_i,
  output logic expire_o
);

  localparam int unsigned CW = cnt_width(TIMEOUT);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

  logic [CW-1:0] cnt_q, cnt_d;

  // Saturating count; expiry itself restarts the window.
  always_comb begin
    expire_o = (TIMEOUT != 0) && en_i && (cnt_q == LIMIT);
    cnt_d    = cnt_q;
    if (!en_i || clr_i || expire_o) begin
      cnt_d = '0;
    end else if (cnt_q < LIMIT) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/wb_sdram_arbiter.sv
// Two-master round-robin Wishbone arbiter in front of the SDRAM controller;
// the owner holds the bus for the whole CYC so bursts pass through intact.
module wb_sdram_arbiter
  import wb_sdram_arbiter_pkg::*;
#(
  parameter int unsigned DW      = 32,
  parameter int unsigned AW      = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic [AW-1:0]   m0_adr_i,
  input  logic [DW-1:0]   m0_dat_i,
  input  logic [DW/8-1:0] m0_sel_i,
  input  logic            m0_we_i,
  input  logic            m0_cyc_i,
  input  logic            m0_stb_i,
  input  logic [2:0]      m0_cti_i,
  input  logic [1:0]      m0_bte_i,
  output logic [DW-1:0]   m0_dat_o,
  output logic            m0_ack_o,
  output logic            m0_err_o,
  input  logic [AW-1:0]   m1_adr_i,
  input  logic [DW-1:0]   m1_dat_i,
  input  logic [DW/8-1:0] m1_sel_i,
  input  logic            m1_we_i,
  input  logic            m1_cyc_i,
  input  logic            m1_stb_i,
  input  logic [2:0]      m1_cti_i,
  input  logic [1:0]      m1_bte_i,
  output logic [DW-1:0]   m1_dat_o,
  output logic            m1_ack_o,
  output logic            m1_err_o,
  output logic [AW-1:0]   s_adr_o,
  output logic [DW-1:0]   s_dat_o,
  output logic [DW/8-1:0] s_sel_o,
  output logic            s_we_o,
  output logic            s_cyc_o,
  output logic            s_stb_o,
  output logic [2:0]      s_cti_o,
  output logic [1:0]      s_bte_o,
  input  logic [DW-1:0]   s_dat_i,
  input  logic            s_ack_i,
  input  logic            s_err_i,
  output logic [1:0]      grant_o
);

  arb_state_e state_q, state_d;
  logic       last_q, last_d;
  logic       wd_en, wd_expire, wd_err;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= ARB_IDLE;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  // Ownership changes only when the owner drops CYC; ties go to the non-last master.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (m0_cyc_i && m1_cyc_i) begin
          state_d = last_q ? ARB_OWN0 : ARB_OWN1;
        end else if (m0_cyc_i) begin
          state_d = ARB_OWN0;
        end else if (m1_cyc_i) begin
          state_d = ARB_OWN1;
        end
      end
      ARB_OWN0: begin
        if (!m0_cyc_i) begin
          last_d  = 1'b0;
          state_d = m1_cyc_i ? ARB_OWN1 : ARB_IDLE;
        end
      end
      ARB_OWN1: begin
        if (!m1_cyc_i) begin
          last_d  = 1'b1;
          state_d = m0_cyc_i ? ARB_OWN0 : ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  assign wd_en  = ((state_q == ARB_OWN0) && m0_cyc_i && m0_stb_i) ||
                  ((state_q == ARB_OWN1) && m1_cyc_i && m1_stb_i);
  assign wd_err = wd_expire && !s_ack_i;

  wb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk_i    (wb_clk_i),
    .rst_i    (wb_rst_i),
    .en_i     (wd_en),
    .clr_i    (s_ack_i | s_err_i),
    .expire_o (wd_expire)
  );

  // Request mux and response steering; an expiring request is withdrawn from the slave.
  always_comb begin
    s_adr_o  = '0;
    s_dat_o  = '0;
    s_sel_o  = '0;
    s_we_o   = 1'b0;
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_cti_o  = '0;
    s_bte_o  = '0;
    m0_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m1_ack_o = 1'b0;
    m1_err_o = 1'b0;
    grant_o  = 2'b00;
    m0_dat_o = s_dat_i;
    m1_dat_o = s_dat_i;
    unique case (state_q)
      ARB_OWN0: begin
        s_adr_o  = m0_adr_i;
        s_dat_o  = m0_dat_i;
        s_sel_o  = m0_sel_i;
        s_we_o   = m0_we_i;
        s_cyc_o  = m0_cyc_i && !wd_expire;
        s_stb_o  = m0_stb_i && !wd_expire;
        s_cti_o  = m0_cti_i;
        s_bte_o  = m0_bte_i;
        m0_ack_o = s_ack_i;
        m0_err_o = s_err_i || wd_err;
        grant_o  = 2'b01;
      end
      ARB_OWN1: begin
        s_adr_o  = m1_adr_i;
        s_dat_o  = m1_dat_i;
        s_sel_o  = m1_sel_i;
        s_we_o   = m1_we_i;
        s_cyc_o  = m1_cyc_i && !wd_expire;
        s_stb_o  = m1_stb_i && !wd_expire;
        s_cti_o  = m1_cti_i;
        s_bte_o  = m1_bte_i;
        m1_ack_o = s_ack_i;
        m1_err_o = s_err_i || wd_err;
        grant_o  = 2'b10;
      end
      default: ;
    endcase
  end

endmodule
